// File: rtl/proc_seq_pkg.sv
// Shared definitions for the three-stage process-chain sequencer.
//
// Contents:
//   stage_state_e    per-stage FSM state (ST_IDLE, ST_RUN)
//   STG_A/B/C        stage indices (processA, processB, processC)
//   DEF_BX_W         default BX tag width (also the memory page select)
//   DEF_MAX_INFLIGHT default limit on BXs accepted but not yet finished
//   ptr_width()      pointer width for a circular buffer of a given depth
package proc_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } stage_state_e;

  localparam int unsigned STG_A = 0;
  localparam int unsigned STG_B = 1;
  localparam int unsigned STG_C = 2;

  localparam int unsigned DEF_BX_W         = 2;
  localparam int unsigned DEF_MAX_INFLIGHT = 2;

  // A depth-1 buffer still needs a one-bit pointer to stay legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bx_token_fifo.sv
// Small circular FIFO of BX tags feeding one downstream stage.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset (empties the FIFO)
//   push, din   write a tag; dropped and flagged if full and not popping
//   pop, dout   read the head tag; dout is valid whenever empty is low
//   empty, full occupancy status
//   overflow    combinational: a push was dropped this cycle
//
// A push and a pop in the same cycle are both honoured, even when full:
// the head slot is read out before it is overwritten.
module bx_token_fifo
  import proc_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_INFLIGHT,
  parameter int unsigned WIDTH = DEF_BX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & ~do_push;
  assign dout     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/proc_chain_sequencer.sv
// Sequencer for a chain of HLS stages joined by page-indexed BRAMs.
// Each BX is started on stage 0, then handed down the chain one stage at a
// time, so several BXs may occupy different stages concurrently. The number
// of BXs in flight is capped so a page is never rewritten before it is read.
//
// Ports:
//   clk, reset    clock; synchronous active-high reset (also each stage's ap_rst)
//   evt_valid     new event offered, with its BX on bx_in
//   evt_ready     event accepted when evt_valid & evt_ready
//   start_o[k]    one-cycle ap_start pulse for stage k
//   done_i[k]     ap_done from stage k (only honoured while stage k runs)
//   bx_o          BX/page for stage k at [k*BX_W +: BX_W], held for the run
//   busy_o[k]     stage k is running
//   bx_out_valid  one-cycle pulse, last stage finished bx_out
//   inflight_o    BXs accepted but not yet finished by the last stage
//   err_o         sticky protocol error (done while idle, token overflow)
module proc_chain_sequencer
  import proc_seq_pkg::*;
#(
  parameter int unsigned NSTAGE       = STG_C + 1,
  parameter int unsigned BX_W         = DEF_BX_W,
  parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               evt_valid,
  input  logic [BX_W-1:0]                    bx_in,
  output logic                               evt_ready,
  output logic [NSTAGE-1:0]                  start_o,
  input  logic [NSTAGE-1:0]                  done_i,
  output logic [NSTAGE*BX_W-1:0]             bx_o,
  output logic [NSTAGE-1:0]                  busy_o,
  output logic                               bx_out_valid,
  output logic [BX_W-1:0]                    bx_out,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_o,
  output logic                               err_o
);

  localparam int unsigned IW   = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned LAST = NSTAGE - 1;

  logic              accept;
  logic [NSTAGE-1:0] done_ok;
  logic [NSTAGE-1:0] done_bad;
  logic [NSTAGE-1:0] fifo_ovf;
  logic [BX_W-1:0]   stage_bx [NSTAGE];

  logic [IW-1:0]     inflight_q;
  logic              err_q;
  logic              out_valid_q;
  logic [BX_W-1:0]   out_bx_q;

  // done is only meaningful from a running stage; anything seen in reset is dropped.
  assign done_ok  = done_i & busy_o & {NSTAGE{~reset}};
  assign done_bad = done_i & ~busy_o & {NSTAGE{~reset}};

  assign evt_ready = ~busy_o[STG_A] & (inflight_q < IW'(MAX_INFLIGHT)) & ~reset;
  assign accept    = evt_valid & evt_ready;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    stage_state_e    state_q;
    logic            start_q;
    logic [BX_W-1:0] bx_q;
    logic            launch;
    logic [BX_W-1:0] launch_bx;

    if (k < STG_B) begin : g_src_evt
      assign launch      = accept;
      assign launch_bx   = bx_in;
      assign fifo_ovf[k] = 1'b0;
    end else begin : g_src_fifo
      logic            free;
      logic            bypass;
      logic            push;
      logic            pop;
      logic            empty;
      logic            full;
      logic [BX_W-1:0] dout;

      // A stage finishing this cycle can take its next tag on the same edge.
      assign free   = (state_q == ST_IDLE) | done_ok[k];
      // Upstream tag goes straight to the stage when nothing is queued ahead.
      assign bypass = free & empty;
      assign push   = done_ok[k-1] & ~bypass;
      assign pop    = free & ~empty;
      assign launch = pop | (bypass & done_ok[k-1]);
      assign launch_bx = empty ? stage_bx[k-1] : dout;

      bx_token_fifo #(
        .DEPTH(MAX_INFLIGHT),
        .WIDTH(BX_W)
      ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .din     (stage_bx[k-1]),
        .dout    (dout),
        .empty   (empty),
        .full    (full),
        .overflow(fifo_ovf[k])
      );

      // Tokens never exceed the in-flight cap, so a lossy push means a broken invariant.
      a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop));
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        start_q <= 1'b0;
        bx_q    <= '0;
      end else begin
        start_q <= launch;
        if (launch) begin
          state_q <= ST_RUN;
          bx_q    <= launch_bx;
        end else if (done_ok[k]) begin
          state_q <= ST_IDLE;
        end
      end
    end

    assign start_o[k]               = start_q;
    assign busy_o[k]                = (state_q == ST_RUN);
    assign bx_o[k*BX_W +: BX_W]     = bx_q;
    assign stage_bx[k]              = bx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q  <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_bx_q    <= '0;
    end else begin
      if (accept && !done_ok[LAST]) begin
        inflight_q <= inflight_q + IW'(1);
      end else if (done_ok[LAST] && !accept) begin
        inflight_q <= inflight_q - IW'(1);
      end
      if ((|done_bad) || (|fifo_ovf)) begin
        err_q <= 1'b1;
      end
      out_valid_q <= done_ok[LAST];
      if (done_ok[LAST]) begin
        out_bx_q <= stage_bx[LAST];
      end
    end
  end

  assign inflight_o   = inflight_q;
  assign err_o        = err_q;
  assign bx_out_valid = out_valid_q;
  assign bx_out       = out_bx_q;

endmodule

// File: tb/tb_proc_chain_sequencer.sv
// Bench for proc_chain_sequencer: stage responders answer start_o with done_i
// after a per-stage latency, a scoreboard queue holds the expected bx_out
// sequence, and directed scenarios check start/done/output cycle timing.
module tb_proc_chain_sequencer;

  localparam int NST = 3;
  localparam int BW  = 2;
  localparam int MI  = 2;
  localparam int IWT = $clog2(MI + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             evt_valid;
  logic [BW-1:0]    bx_in;
  logic             evt_ready;
  logic [NST-1:0]   start_o;
  logic [NST-1:0]   done_i;
  logic [NST*BW-1:0] bx_o;
  logic [NST-1:0]   busy_o;
  logic             bx_out_valid;
  logic [BW-1:0]    bx_out;
  logic [IWT-1:0]   inflight_o;
  logic             err_o;

  logic           resp [NST] = '{1'b0, 1'b0, 1'b0};
  logic [NST-1:0] man;
  int             lat [NST];
  int             epoch = 0;
  int             cyc = 0;
  int             n_vec = 0;
  int             n_bad = 0;
  int             last_done2 = -10;

  typedef struct {
    int cyc;
    int stg;
    int bx;
  } ev_t;

  int  exp_q [$];
  ev_t starts [$];
  ev_t dones [$];
  int  outs [$];

  proc_chain_sequencer #(
    .NSTAGE      (NST),
    .BX_W        (BW),
    .MAX_INFLIGHT(MI)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .evt_valid   (evt_valid),
    .bx_in       (bx_in),
    .evt_ready   (evt_ready),
    .start_o     (start_o),
    .done_i      (done_i),
    .bx_o        (bx_o),
    .busy_o      (busy_o),
    .bx_out_valid(bx_out_valid),
    .bx_out      (bx_out),
    .inflight_o  (inflight_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign done_i = {resp[2] | man[2], resp[1] | man[1], resp[0] | man[0]};

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Stage models: done_i[k] rises lat[k] cycles after start_o[k]; a reset in
  // between cancels the pending done.
  for (genvar k = 0; k < NST; k++) begin : g_resp
    initial begin
      int ep;
      int l;
      forever begin
        @(negedge clk);
        if (start_o[k]) begin
          ep = epoch;
          l  = lat[k];
          repeat (l) @(posedge clk);
          #1;
          if (ep == epoch) resp[k] = 1'b1;
          @(posedge clk);
          #1;
          resp[k] = 1'b0;
        end
      end
    end
  end

  // Monitor: event logs plus scoreboard compare on every bx_out_valid.
  always @(negedge clk) begin
    ev_t e;
    for (int k = 0; k < NST; k++) begin
      if (start_o[k]) begin
        e.cyc = cyc;
        e.stg = k;
        e.bx  = int'(bx_o[k*BW +: BW]);
        starts.push_back(e);
      end
      if (done_i[k]) begin
        e.cyc = cyc;
        e.stg = k;
        e.bx  = 0;
        dones.push_back(e);
      end
    end
    if (bx_out_valid) begin
      outs.push_back(cyc);
      chk("out_one_after_done2", last_done2, cyc - 1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL bx_out_unexpected: actual %0d, required no output", bx_out);
      end else begin
        chk("bx_out", int'(bx_out), exp_q.pop_front());
      end
    end
    if (done_i[2]) last_done2 = cyc;
  end

  function automatic int start_cyc(input int stg, input int n);
    int c = 0;
    foreach (starts[i]) begin
      if (starts[i].stg == stg) begin
        if (c == n) return starts[i].cyc;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int start_bx(input int stg, input int n);
    int c = 0;
    foreach (starts[i]) begin
      if (starts[i].stg == stg) begin
        if (c == n) return starts[i].bx;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int done_cyc(input int stg, input int n);
    int c = 0;
    foreach (dones[i]) begin
      if (dones[i].stg == stg) begin
        if (c == n) return dones[i].cyc;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int out_cyc(input int n);
    if (n < outs.size()) return outs[n];
    return -1;
  endfunction

  // Call aligned #1 after a posedge. acc is the cycle the event was accepted.
  task automatic send(input int bx, output int acc);
    int n = 0;
    acc       = -1;
    evt_valid = 1'b1;
    bx_in     = bx[BW-1:0];
    while (acc < 0 && n < 300) begin
      @(negedge clk);
      if (evt_ready) acc = cyc;
      n++;
    end
    @(posedge clk);
    #1;
    evt_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", n, -1);
    else exp_q.push_back(bx);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && inflight_o == 0 && busy_o == 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk(name, n, -1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    starts.delete();
    dones.delete();
    outs.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_start_o"}, start_o, 0);
    chk({tag, "_busy_o"}, busy_o, 0);
    chk({tag, "_bx_o"}, bx_o, 0);
    chk({tag, "_bx_out_valid"}, bx_out_valid, 0);
    chk({tag, "_inflight"}, inflight_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int a;
    int b;
    int c;
    reset     = 1'b1;
    evt_valid = 1'b0;
    bx_in     = '0;
    man       = '0;
    lat       = '{5, 5, 5};
    tick(3);

    // Reset state
    @(negedge clk);
    chk("rst_evt_ready", evt_ready, 0);
    check_reset_values("rst");
    chk("rst_bx_out", bx_out, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(2);

    // 1: single event through all stages
    clear_logs();
    send(2, a);
    chk("t1_inflight_up", inflight_o, 1);
    wait_drain("t1_drain_timeout");
    chk("t1_start0_cyc", start_cyc(0, 0), a + 1);
    chk("t1_start1_cyc", start_cyc(1, 0), a + 7);
    chk("t1_start2_cyc", start_cyc(2, 0), a + 13);
    for (int k = 0; k < NST; k++) chk("t1_stage_bx", start_bx(k, 0), 2);
    chk("t1_out_cyc", out_cyc(0), a + 19);
    chk("t1_inflight_down", inflight_o, 0);

    // 2: pipelining with a slow middle stage
    clear_logs();
    lat = '{5, 20, 5};
    send(0, a);
    send(1, b);
    chk("t2_accept1_cyc", b, a + 7);
    wait_drain("t2_drain_timeout");
    chk("t2_s1_bx0_start", start_cyc(1, 0), a + 7);
    chk("t2_s0_bx1_start", start_cyc(0, 1), a + 8);
    chk("t2_s1_bx0_done", done_cyc(1, 0), a + 27);
    chk("t2_s1_bx1_start", start_cyc(1, 1), a + 28);
    chk("t2_s1_bx1_tag", start_bx(1, 1), 1);
    chk("t2_out0_cyc", out_cyc(0), a + 34);
    chk("t2_out1_cyc", out_cyc(1), a + 55);

    // 3: in-flight limit
    clear_logs();
    lat = '{5, 5, 5};
    send(1, a);
    send(2, b);
    chk("t3_accept2_cyc", b, a + 7);
    @(negedge clk);
    chk("t3_ready_low_at_limit", evt_ready, 0);
    chk("t3_inflight_at_limit", inflight_o, 2);
    @(posedge clk);
    #1;
    send(3, c);
    chk("t3_accept3_cyc", c, a + 19);
    chk("t3_accept3_with_out0", c, out_cyc(0));
    wait_drain("t3_drain_timeout");
    chk("t3_bx3_start0", start_cyc(0, 2), a + 20);
    chk("t3_bx3_tag", start_bx(0, 2), 3);

    // 4: tag wrap 3 -> 0
    clear_logs();
    send(3, a);
    send(0, b);
    wait_drain("t4_drain_timeout");
    chk("t4_out_count", outs.size(), 2);
    chk("t4_err", err_o, 0);

    // 5: spurious done on idle stage 1
    clear_logs();
    man[1] = 1'b1;
    @(negedge clk);
    chk("t5_err_registered", err_o, 0);
    @(posedge clk);
    #1;
    man[1] = 1'b0;
    @(negedge clk);
    chk("t5_err_set", err_o, 1);
    tick(5);
    @(negedge clk);
    chk("t5_err_held", err_o, 1);
    chk("t5_no_start", starts.size(), 0);
    @(posedge clk);
    #1;

    // 6: reset mid-run with a tag queued for stage 1
    clear_logs();
    lat = '{5, 20, 5};
    send(2, a);
    send(3, b);
    tick(8);
    chk("t6_stage1_running", busy_o[1], 1);
    reset  = 1'b1;
    man[2] = 1'b1;
    epoch++;
    exp_q.delete();
    @(negedge clk);
    chk("t6_ready_in_reset", evt_ready, 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    man[2] = 1'b0;
    @(negedge clk);
    check_reset_values("t6");
    @(negedge clk);
    chk("t6_err_after", err_o, 0);
    chk("t6_no_out_after", bx_out_valid, 0);
    @(posedge clk);
    #1;
    tick(15);
    clear_logs();
    lat = '{5, 5, 5};
    send(1, a);
    wait_drain("t6_drain_timeout");
    chk("t6_out_count", outs.size(), 1);
    chk("t6_err_clean", err_o, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
